// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter whose state is a bank of T flip-flops (Q <= Q ^ T).
// Latency: Q and Wrap update on the sampling edge; T and TC are combinational in the same cycle.
// No backpressure: count/load requests are accepted every cycle; cascade by feeding TC to the next En.
//
// Ports:
//   clock  - rising-edge clock
//   clear  - asynchronous active-low reset (Q = 0, Wrap = 0)
//   en     - count enable
//   up     - direction, 1 = increment, 0 = decrement
//   load   - synchronous load strobe, overrides en/up
//   d      - load value; values >= MODULUS load as 0
//   q      - registered count
//   qbar   - bitwise complement of q
//   t      - toggle vector applied at the next edge
//   tc     - terminal count, cascade enable for the next stage
//   wrap   - one-cycle registered pulse after a wrap edge
module tff_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] t,
    output logic             tc,
    output logic             wrap
);

    // One extra bit so MODULUS = 2^WIDTH is representable for the range checks.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_cnt;
    logic             at_max;
    logic             at_zero;
    logic             illegal;
    logic             d_legal;

    assign at_max  = (q == MAX_CNT);
    assign at_zero = (q == '0);
    assign illegal = ({1'b0, q} >= MOD_EXT);
    assign d_legal = ({1'b0, d} < MOD_EXT);

    always_comb begin
        next_cnt = q;
        if (load) begin
            next_cnt = d_legal ? d : '0;
        end else if (en) begin
            // An out-of-range state recovers to 0 on its first counting step.
            if (illegal) begin
                next_cnt = '0;
            end else if (up) begin
                next_cnt = at_max ? '0 : q + WIDTH'(1);
            end else begin
                next_cnt = at_zero ? MAX_CNT : q - WIDTH'(1);
            end
        end
    end

    // Toggle only the bits that differ between current and next count.
    assign t    = q ^ next_cnt;
    assign tc   = en & ~load & (up ? at_max : at_zero);
    assign qbar = ~q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q ^ t;
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_tff_mod_counter.sv
module tb_tff_mod_counter;

    logic       clock;
    logic       clear;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] qbar;
    logic [3:0] t;
    logic       tc;
    logic       wrap;

    int tests_run = 0;
    int tests_failed = 0;

    tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clock (clock),
        .clear (clear),
        .en    (en),
        .up    (up),
        .load  (load),
        .d     (d),
        .q     (q),
        .qbar  (qbar),
        .t     (t),
        .tc    (tc),
        .wrap  (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Load a value with counting disabled; leaves load low afterwards.
    task automatic do_load(input logic [3:0] val);
        load = 1'b1; en = 1'b0; d = val;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset;
        clear = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; d = 4'd0;
        repeat (3) tick();
        tests_run++;
        if (q !== 4'd0) begin tests_failed++; $display("FAIL reset_q: got %0d expected 0", q); end
        tests_run++;
        if (qbar !== 4'b1111) begin tests_failed++; $display("FAIL reset_qbar: got %b expected 1111", qbar); end
        tests_run++;
        if (wrap !== 1'b0) begin tests_failed++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        tests_run++;
        if (t !== 4'b0001) begin tests_failed++; $display("FAIL reset_t: got %b expected 0001", t); end
        tests_run++;
        if (tc !== 1'b0) begin tests_failed++; $display("FAIL reset_tc: got %b expected 0", tc); end
        up = 1'b0;
        #1;
        tests_run++;
        if (tc !== 1'b1) begin tests_failed++; $display("FAIL reset_tc_down: got %b expected 1", tc); end
        up = 1'b1;
    endtask

    task automatic test_count_sequence;
        logic [3:0] exp_q;
        logic       exp_wrap;
        clear = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_q    = (i == 10) ? 4'd0 : 4'(i);
            exp_wrap = (i == 10);
            tests_run++;
            if (q !== exp_q) begin tests_failed++; $display("FAIL count_q step %0d: got %0d expected %0d", i, q, exp_q); end
            tests_run++;
            if (wrap !== exp_wrap) begin tests_failed++; $display("FAIL count_wrap step %0d: got %b expected %b", i, wrap, exp_wrap); end
        end
    endtask

    task automatic test_up_wrap;
        do_load(4'd8);
        tests_run++;
        if (q !== 4'd8) begin tests_failed++; $display("FAIL upwrap_load: got %0d expected 8", q); end
        en = 1'b1; up = 1'b1;
        #1;
        tests_run++;
        if (t !== 4'b0001 || tc !== 1'b0) begin tests_failed++; $display("FAIL upwrap_at8: got t=%b tc=%b expected t=0001 tc=0", t, tc); end
        tick();
        tests_run++;
        if (q !== 4'd9 || tc !== 1'b1 || t !== 4'b1001) begin
            tests_failed++; $display("FAIL upwrap_at9: got q=%0d tc=%b t=%b expected q=9 tc=1 t=1001", q, tc, t);
        end
        tick();
        tests_run++;
        if (q !== 4'd0 || wrap !== 1'b1 || tc !== 1'b0) begin
            tests_failed++; $display("FAIL upwrap_at0: got q=%0d wrap=%b tc=%b expected q=0 wrap=1 tc=0", q, wrap, tc);
        end
        tick();
        tests_run++;
        if (q !== 4'd1 || wrap !== 1'b0) begin tests_failed++; $display("FAIL upwrap_after: got q=%0d wrap=%b expected q=1 wrap=0", q, wrap); end
    endtask

    task automatic test_down_wrap;
        do_load(4'd1);
        en = 1'b1; up = 1'b0;
        tick();
        tests_run++;
        if (q !== 4'd0 || tc !== 1'b1 || t !== 4'b1001) begin
            tests_failed++; $display("FAIL downwrap_at0: got q=%0d tc=%b t=%b expected q=0 tc=1 t=1001", q, tc, t);
        end
        tick();
        tests_run++;
        if (q !== 4'd9 || wrap !== 1'b1) begin tests_failed++; $display("FAIL downwrap_at9: got q=%0d wrap=%b expected q=9 wrap=1", q, wrap); end
        tick();
        tests_run++;
        if (q !== 4'd8 || wrap !== 1'b0) begin tests_failed++; $display("FAIL downwrap_after: got q=%0d wrap=%b expected q=8 wrap=0", q, wrap); end
    endtask

    task automatic test_load_priority;
        do_load(4'd5);
        load = 1'b1; en = 1'b1; up = 1'b1; d = 4'd3;
        #1;
        tests_run++;
        if (t !== 4'b0110 || tc !== 1'b0) begin tests_failed++; $display("FAIL load_t: got t=%b tc=%b expected t=0110 tc=0", t, tc); end
        tick();
        tests_run++;
        if (q !== 4'd3 || wrap !== 1'b0) begin tests_failed++; $display("FAIL load_3: got q=%0d wrap=%b expected q=3 wrap=0", q, wrap); end
        d = 4'd12;
        tick();
        tests_run++;
        if (q !== 4'd0) begin tests_failed++; $display("FAIL load_clamp: got %0d expected 0", q); end
        // Load at the terminal count must suppress TC and Wrap.
        do_load(4'd9);
        load = 1'b1; en = 1'b1; up = 1'b1; d = 4'd2;
        #1;
        tests_run++;
        if (tc !== 1'b0) begin tests_failed++; $display("FAIL load_tc_mask: got %b expected 0", tc); end
        tick();
        tests_run++;
        if (q !== 4'd2 || wrap !== 1'b0) begin tests_failed++; $display("FAIL load_at9: got q=%0d wrap=%b expected q=2 wrap=0", q, wrap); end
        load = 1'b0;
    endtask

    task automatic test_hold;
        do_load(4'd7);
        en = 1'b0; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (q !== 4'd7 || t !== 4'd0 || tc !== 1'b0) begin
                tests_failed++; $display("FAIL hold edge %0d: got q=%0d t=%b tc=%b expected q=7 t=0000 tc=0", i, q, t, tc);
            end
        end
    endtask

    task automatic test_direction_change;
        do_load(4'd3);
        en = 1'b1; up = 1'b1;
        tick();
        tests_run++;
        if (q !== 4'd4) begin tests_failed++; $display("FAIL dir_up: got %0d expected 4", q); end
        up = 1'b0;
        tick();
        tests_run++;
        if (q !== 4'd3) begin tests_failed++; $display("FAIL dir_down: got %0d expected 3", q); end
    endtask

    task automatic test_async_reset;
        do_load(4'd5);
        en = 1'b1; up = 1'b1;
        tick();
        tests_run++;
        if (q !== 4'd6) begin tests_failed++; $display("FAIL areset_pre: got %0d expected 6", q); end
        #2 clear = 1'b0;
        #1;
        tests_run++;
        if (q !== 4'd0 || qbar !== 4'b1111 || wrap !== 1'b0) begin
            tests_failed++; $display("FAIL areset_mid: got q=%0d qbar=%b wrap=%b expected q=0 qbar=1111 wrap=0", q, qbar, wrap);
        end
        tick();
        tests_run++;
        if (q !== 4'd0) begin tests_failed++; $display("FAIL areset_hold: got %0d expected 0", q); end
        clear = 1'b1;
        tick();
        tests_run++;
        if (q !== 4'd1) begin tests_failed++; $display("FAIL areset_release: got %0d expected 1", q); end
    endtask

    initial begin
        clear = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
        #1;
        test_reset();
        test_count_sequence();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_hold();
        test_direction_change();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tff_mod_counter.md
# tff_mod_counter

Modulo-N synchronous up/down counter built from per-bit toggle (T) flip-flop state, with the toggle-enable equations generated internally. Sits directly upstream of and around the T flip-flop stage: it computes the T vector each cycle, holds the toggling state, and exposes both so downstream dividers and cascaded counters can consume count, toggle and terminal-count signals. Intended for decade/modulo counting, clock-enable division and cascading via TC.

## Interface
- WIDTH, 4, state width in bits
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH
- Clock  input  1  rising-edge clock
- Clear  input  1  asynchronous active-low reset
- En  input  1  count enable
- Up  input  1  direction: 1 = increment, 0 = decrement
- Load  input  1  synchronous load strobe
- D  input  WIDTH  load value
- Q  output  WIDTH  registered count
- Qbar  output  WIDTH  bitwise complement of Q
- T  output  WIDTH  toggle vector applied at the next edge (combinational)
- TC  output  1  terminal count (combinational)
- Wrap  output  1  registered one-cycle pulse after a wrap

## Operation
- State is WIDTH T-type bits: each edge, Q <= Q ^ T.
- T is derived from next-count: T = Q ^ next; T = 0 when next equals Q.
- Next-count priority, highest first:
  - Load = 1: next = D if D < MODULUS, else 0. En and Up ignored.
  - En = 1, Up = 1: next = Q + 1; Q = MODULUS-1 wraps to 0.
  - En = 1, Up = 0: next = Q - 1; Q = 0 wraps to MODULUS-1.
  - En = 0: next = Q (T = 0, hold).
- When MODULUS = 2^WIDTH the wrap is natural binary overflow; same T equations.
- Illegal state (Q >= MODULUS, reachable only through a corrupt load path): next counting step forces Q to 0 in either direction.
- TC = En & ~Load & (Up ? Q == MODULUS-1 : Q == 0). TC is the cascade enable for the next stage's En.
- Wrap is set for one cycle after any edge where TC was 1; cleared otherwise. Load never sets Wrap.
- Qbar = ~Q at all times, including during reset.

## Timing
- Reset (Clear = 0, asynchronous, independent of Clock): Q = 0, Qbar = all ones, Wrap = 0. T and TC follow their equations from Q = 0 (TC = En & ~Load & ~Up).
- Clear deasserted: first active edge is the first edge at which Clear is sampled high; no edge is lost or doubled.
- Reset asserted mid-count: Q goes to 0 immediately, no wait for clock; a pending Load or count is discarded.
- Count latency: Q updates on the edge at which En/Load are sampled; T and TC valid combinationally in the same cycle as their inputs.
- Wrap latency: one cycle after the TC edge; aligned with Q showing the wrapped value.
- Simultaneous Load and En: Load wins, Wrap stays 0.
- Direction change: Up takes effect on the same edge it is sampled; no pipeline state.

## Test plan
- Reset: Clear = 0 with En = 1, Up = 1 for 3 edges -> Q = 0, Qbar = 4'b1111, Wrap = 0; release Clear, 10 edges -> Q steps 1..9 then 0.
- Up wrap (WIDTH 4, MODULUS 10): Load D = 8, then En = 1, Up = 1 -> Q 9 with TC = 1, then Q 0 with Wrap = 1 for exactly one cycle; T = 4'b1001 in the cycle when Q = 9.
- Down wrap: Load D = 1, En = 1, Up = 0 -> Q 0 (TC = 1), then Q 9, Wrap = 1 one cycle; T = 4'b1001 in the cycle when Q = 0.
- Load priority/clamp: Q = 5, Load = 1, En = 1, D = 3 -> Q = 3, Wrap = 0; D = 12 -> Q = 0.
- Hold: En = 0 for 5 edges at Q = 7 -> Q stays 7, T = 0, TC = 0.
- Async reset mid-count: at Q = 6 assert Clear between edges -> Q = 0 before the next edge; Wrap = 0.
